// File: rtl/spi_cmd_pkg.sv
// Shared types and command-byte field positions for the SPI command decoder.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam int         CMD_W_BIT   = 7;
    localparam int         CMD_INC_BIT = 6;
    localparam int         CMD_RSV_MSB = 5;
    localparam int         CMD_RSV_LSB = 4;
    localparam logic [7:0] ERR_FILL    = 8'hFF;

endpackage

// File: rtl/spi_cmd_decoder.sv
// Interprets SPI frames from the byte shifter: byte 0 is a command, later bytes are
// write data or read dummies. Drives a register-file write port and feeds MISO bytes back.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_active,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_load,
    output logic              wr_en,
    output logic [3:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [3:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              err,
    output logic              busy
);

    localparam logic [3:0] LAST_ADDR = 4'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic              cs_prev_q, cs_prev_d;
    logic [3:0]        addr_q, addr_d;
    logic              wr_mode_q, wr_mode_d;
    logic              inc_q, inc_d;
    logic              ld_pend_q, ld_pend_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_load_q, tx_load_d;
    logic              wr_en_q, wr_en_d;
    logic [3:0]        wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [3:0]        rd_addr_q, rd_addr_d;
    logic              err_q, err_d;

    logic       cs_rise;
    logic       byte_ok;
    logic       cmd_bad;
    logic [3:0] next_addr;

    assign cs_rise   = cs_active & ~cs_prev_q;
    // A byte arriving together with CS release belongs to no frame and is dropped.
    assign byte_ok   = rx_valid & cs_active;
    assign cmd_bad   = (rx_data[CMD_RSV_MSB:CMD_RSV_LSB] != 2'b00) || (rx_data[3:0] > LAST_ADDR);
    assign next_addr = (addr_q == LAST_ADDR) ? 4'd0 : addr_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!cs_active) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (cs_rise) state_d = CMD;
                CMD:     if (rx_valid) state_d = cmd_bad ? ERR : DATA;
                DATA:    state_d = DATA;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every _d starts from its hold value so no path through the case infers a latch.
        cs_prev_d = cs_active;
        addr_d    = addr_q;
        wr_mode_d = wr_mode_q;
        inc_d     = inc_q;
        ld_pend_d = 1'b0;
        tx_data_d = tx_data_q;
        tx_load_d = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (cs_rise) err_d = 1'b0;
            end
            CMD: begin
                if (byte_ok) begin
                    if (cmd_bad) begin
                        err_d     = 1'b1;
                        tx_data_d = ERR_FILL;
                    end else begin
                        addr_d    = rx_data[3:0];
                        wr_mode_d = rx_data[CMD_W_BIT];
                        inc_d     = rx_data[CMD_INC_BIT];
                        if (!rx_data[CMD_W_BIT]) begin
                            rd_addr_d = rx_data[3:0];
                            ld_pend_d = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                // rd_data reflects rd_addr_q one cycle after it was updated.
                if (ld_pend_q && cs_active) begin
                    tx_data_d = rd_data;
                    tx_load_d = 1'b1;
                end
                if (byte_ok) begin
                    if (wr_mode_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = rx_data;
                    end else begin
                        ld_pend_d = 1'b1;
                        if (inc_q) rd_addr_d = next_addr;
                    end
                    if (inc_q) addr_d = next_addr;
                end
            end
            ERR: begin
                tx_data_d = ERR_FILL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: CS is treated as already high at reset, so a frame open across reset is ignored
            // until CS drops and rises again.
            cs_prev_q <= 1'b1;
            addr_q    <= '0;
            wr_mode_q <= 1'b0;
            inc_q     <= 1'b0;
            ld_pend_q <= 1'b0;
            tx_data_q <= '0;
            tx_load_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            cs_prev_q <= cs_prev_d;
            addr_q    <= addr_d;
            wr_mode_q <= wr_mode_d;
            inc_q     <= inc_d;
            ld_pend_q <= ld_pend_d;
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            err_q     <= err_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_load = tx_load_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_addr = rd_addr_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);

endmodule
